// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic tile feeder path.
package systolic_pkg;

  localparam int NIB_W     = 4;
  localparam int WORD_W    = 16;
  localparam int CTRL_W    = 4;
  localparam int BLOCK_LEN = 4;

  // Read-address codes carried in ctrl[3:2]; decoded by the tile, not here.
  localparam logic [1:0] ADDR_C01 = 2'd2;
  localparam logic [1:0] ADDR_C23 = 2'd3;

  typedef struct packed {
    logic [WORD_W-1:0] col;
    logic [WORD_W-1:0] row;
    logic [CTRL_W-1:0] colctl;
    logic [CTRL_W-1:0] rowctl;
  } entry_t;

  // Zero words XOR nothing into the accumulators; zero ctrl is pass-through.
  localparam entry_t IDLE_ENTRY = '0;

endpackage

// File: rtl/systolic_entry_fifo.sv
// Small synchronous FIFO of feeder entries with a synchronous clear.
module systolic_entry_fifo
  import systolic_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_q[AW-1:0]];

  // Next pointers: flush rewinds both, otherwise advance on push/pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/systolic_block_feeder.sv
// Buffers operand entries and serializes them MSB-nibble first into
// 4-cycle blocks aligned to the tile's count; idle blocks are all zeros.
module systolic_block_feeder
  import systolic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NIB   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_col_word,
  input  logic [15:0] in_row_word,
  input  logic [3:0]  in_col_ctrl,
  input  logic [3:0]  in_row_ctrl,
  output logic [3:0]  col_nib,
  output logic [3:0]  row_nib,
  output logic        col_ctrl_bit,
  output logic        row_ctrl_bit,
  output logic [1:0]  phase,
  output logic        underrun
);

  localparam logic [1:0] LAST_PHASE = 2'(BLOCK_LEN - 1);

  entry_t     push_entry, head;
  entry_t     sr_q, sr_d;
  logic [1:0] phase_q, phase_d;
  logic       underrun_q, underrun_d;
  logic       seen_q, seen_d;
  logic       full, empty, push, pop, load;

  assign push_entry = '{col: in_col_word, row: in_row_word,
                        colctl: in_col_ctrl, rowctl: in_row_ctrl};

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign load     = (phase_q == LAST_PHASE);
  // A flush on the load edge wins: the next block is idle.
  assign pop      = load && !empty && !flush;

  systolic_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Next state: load a block on the last phase, otherwise shift one step.
  always_comb begin
    phase_d    = phase_q + 2'd1;
    sr_d       = sr_q;
    underrun_d = underrun_q;
    seen_d     = seen_q;
    if (load) begin
      sr_d = pop ? head : IDLE_ENTRY;
    end else begin
      sr_d.col    = {sr_q.col[WORD_W-NIB-1:0], {NIB{1'b0}}};
      sr_d.row    = {sr_q.row[WORD_W-NIB-1:0], {NIB{1'b0}}};
      sr_d.colctl = {sr_q.colctl[CTRL_W-2:0], 1'b0};
      sr_d.rowctl = {sr_q.rowctl[CTRL_W-2:0], 1'b0};
    end
    if (flush) begin
      underrun_d = 1'b0;
      seen_d     = 1'b0;
    end else begin
      if (load && empty && seen_q) underrun_d = 1'b1;
      if (push) seen_d = 1'b1;
    end
  end

  // State registers; reset releases the tile on the same edge (phase 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      sr_q       <= IDLE_ENTRY;
      underrun_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      sr_q       <= sr_d;
      underrun_q <= underrun_d;
      seen_q     <= seen_d;
    end
  end

  assign col_nib      = sr_q.col[WORD_W-1 -: NIB];
  assign row_nib      = sr_q.row[WORD_W-1 -: NIB];
  assign col_ctrl_bit = sr_q.colctl[CTRL_W-1];
  assign row_ctrl_bit = sr_q.rowctl[CTRL_W-1];
  assign phase        = phase_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/systolic_block_feeder.md
Name: systolic_block_feeder

Overview:
- Upstream stage of the 2x2 systolic accumulator tile.
- Accepts whole 16-bit column/row operand words plus 4-bit control words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each entry into four 4-bit nibbles plus one control bit per stream, MSB first.
- Output is aligned to the tile's 4-cycle block boundary; whenever no entry is pending, it emits an idle block of all zeros.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- NIB, 4, nibble width per cycle (fixed by tile protocol; not to be overridden).

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- flush  input  1  sync clear of FIFO contents; does not touch the phase counter
- in_valid  input  1  entry offered
- in_ready  output  1  entry accepted when in_valid&&in_ready at posedge
- in_col_word  input  16  column operand, [15:12] sent first
- in_row_word  input  16  row operand, [15:12] sent first
- in_col_ctrl  input  4  column control; [3:2] is read address: 2=C0, 3=C2, other=pass-through
- in_row_ctrl  input  4  row control; [3:2]: 2=C1, 3=C3, other=pass-through
- col_nib  output  4  to tile ui_in[7:4]
- row_nib  output  4  to tile ui_in[3:0]
- col_ctrl_bit  output  1  to tile uio_in[3]
- row_ctrl_bit  output  1  to tile uio_in[2]
- phase  output  2  block phase counter, equal to tile count
- underrun  output  1  sticky: a block boundary found FIFO empty after at least one entry was accepted since reset/flush

Behaviour:
- Reset (rst=1 at posedge):
  - phase=0, FIFO empty, all output regs 0, underrun=0, in_ready=0 during the reset cycle.
  - Tile reset must be released on the same edge, so phase tracks the tile count exactly.
- Phase: increments every cycle and wraps 3->0.
- Output regs: a 40-bit shift register {col16,row16,colctl4,rowctl4}; outputs are its top nibbles/bits (registered, no combinational path from inputs).
- Load edge (phase==3):
  - FIFO non-empty: pop the head into the shift register.
  - FIFO empty: load all-zero idle block. Idle ctrl=0000, so it is pass-through, and XOR of zero leaves the accumulators unchanged.
- Other edges: shift left by one nibble per word and one bit per ctrl.
- Latency: a word accepted at edge t appears on the outputs after the next phase==3 edge at/after t+1, i.e. the earliest full block starts 1-4 cycles later. The tile samples nibble k at count k.
- Handshake:
  - in_ready = !full && !rst, a function of registered state only.
  - A push in the same cycle as a pop on a full FIFO is NOT accepted.
  - A push and pop together on a partially full FIFO: occupancy unchanged.
  - A push into an empty FIFO at the phase==3 edge is not visible to that same pop; it goes out in the following block.
- flush:
  - Empties the FIFO and clears underrun.
  - Any push in the flush cycle is dropped.
  - The shift register continues its current block undisturbed.
- rst mid-block: the block is aborted, outputs go to 0 immediately at that edge, and all queued entries are lost.
- underrun: set at a phase==3 edge with FIFO empty, but only if an accept has occurred since the last rst/flush. Held until rst/flush.
- FIFO pointers: log2(DEPTH)+1 bits, wrap naturally. full = MSBs differ and LSBs equal.

Decomposition:
- Package systolic_pkg:
  - NIB_W=4, WORD_W=16, CTRL_W=4, BLOCK_LEN=4
  - address codes ADDR_C01=2'd2, ADDR_C23=2'd3
  - entry typedef {col,row,colctl,rowctl}
  - IDLE_ENTRY constant (all zeros)
- One sub-module: systolic_entry_fifo (sync FIFO, DEPTH param, push/pop/flush, full/empty).

Test Plan:
- rst 2 cycles, push {col=0xABCD,row=0x1234,cc=0x0,rc=0x0} at phase 1 -> next block: col_nib A,B,C,D and row_nib 1,2,3,4 on phases 0..3; ctrl bits all 0; in_ready stays 1.
- Push cc=0b1000, rc=0b1100 with any words -> col_ctrl_bit 1,0,0,0 and row_ctrl_bit 1,1,0,0 over phases 0..3.
- Push 3 entries back-to-back with DEPTH=2 -> the third is stalled (in_ready=0) until the first phase==3 pop frees a slot; the words then stream in 3 consecutive blocks with no idle gap and underrun=0.
- No pushes after the last entry -> following block is all zeros and underrun=1 at that phase==3 edge; flush -> underrun=0.
- Full FIFO, then flush mid-block -> current block completes unchanged, next block is idle, in_ready=1 the cycle after flush.
- rst asserted at phase 2 of a non-idle block -> next cycle outputs=0 and phase=0; a new push after release streams correctly (compare against the tile model's C registers after 2 blocks: C0 = {col[15:8],row[15:8]} XOR of both pushes).
